// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types for the uio pad-bus arbiter: FSM state encoding.
package uio_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Rotating priority encoder: first asserted request at or after ptr, wrapping.
module uio_bus_arbiter_rr_pick #(
  parameter int N_REQ   = 4,
  parameter int OWNER_W = 2
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] ptr,
  output logic               valid,
  output logic [OWNER_W-1:0] idx,
  output logic [N_REQ-1:0]   onehot
);

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (req[c]) begin
        valid     = 1'b1;
        idx       = OWNER_W'(c);
        onehot    = '0;
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration of the 8-bit uio pad bus with bounded tenure
// and an undriven turnaround gap between owners.
module uio_bus_arbiter
  import uio_bus_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1,
  localparam int OWNER_W   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [8*N_REQ-1:0]   req_oe,
  output logic [N_REQ-1:0]     gnt,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic                 expired,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = $clog2(TURNAROUND + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [TURN_W-1:0] TURN_MAX = TURN_W'(TURNAROUND);

  arb_state_e         state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [TURN_W-1:0]  turn_cnt;
  logic [OWNER_W-1:0] ptr;

  logic               pick_valid;
  logic [OWNER_W-1:0] pick_idx;
  logic [N_REQ-1:0]   pick_onehot;

  logic               owner_req;
  logic               at_max;
  logic [OWNER_W-1:0] ptr_nxt;

  uio_bus_arbiter_rr_pick #(
    .N_REQ   (N_REQ),
    .OWNER_W (OWNER_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign owner_req = req[owner];
  assign at_max    = (hold_cnt == HOLD_MAX);
  assign ptr_nxt   = (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      ptr      <= '0;
    end else begin
      expired <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ena && pick_valid) begin
            gnt      <= pick_onehot;
            owner    <= pick_idx;
            hold_cnt <= HOLD_W'(1);
            busy     <= 1'b1;
            state    <= S_GRANT;
          end
        end
        S_GRANT: begin
          // ena is deliberately ignored here: only the owner or the tenure limit ends a grant.
          if (!owner_req || at_max) begin
            gnt      <= '0;
            busy     <= 1'b0;
            expired  <= owner_req && at_max;
            ptr      <= ptr_nxt;
            hold_cnt <= '0;
            turn_cnt <= TURN_W'(1);
            state    <= S_TURN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_TURN: begin
          if (turn_cnt == TURN_MAX) state <= S_IDLE;
          else                      turn_cnt <= turn_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // AND-gated mux off the registered one-hot grant; all-zero whenever gnt is zero.
  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      uio_out = uio_out | (req_data[i*8 +: 8] & {8{gnt[i]}});
      uio_oe  = uio_oe  | (req_oe[i*8 +: 8]   & {8{gnt[i]}});
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: directed tenures, monitor checks each tenure at release.
module tb_uio_bus_arbiter;

  localparam int N_REQ = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [3:0]        req;
  logic [31:0]       req_data;
  logic [31:0]       req_oe;
  logic [3:0]        gnt;
  logic [1:0]        owner;
  logic              busy;
  logic              expired;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;

  uio_bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURNAROUND(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .req      (req),
    .req_data (req_data),
    .req_oe   (req_oe),
    .gnt      (gnt),
    .owner    (owner),
    .busy     (busy),
    .expired  (expired),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    int         len;
    logic       expired;
    int         gap;   // expected idle cycles before this tenure, -1 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  function automatic logic [7:0] dat_of(int i);
    return 8'hC0 | 8'(i);
  endfunction

  function automatic logic [7:0] oe_of(int i);
    return 8'(8'h11 * (i + 1));
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(logic [3:0] g, int l, logic x, int gp);
    exp_t e;
    e.gnt = g; e.len = l; e.expired = x; e.gap = gp;
    exp_q.push_back(e);
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: per-cycle bus invariants, tenure length/expiry compared at release.
  logic [3:0] prev_gnt = '0;
  int         cur_len  = 0;
  int         gap_cnt  = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot", int'($onehot0(gnt)), 1);
      if (gnt != 4'b0) begin
        int idx;
        idx = 0;
        for (int i = 0; i < N_REQ; i++) if (gnt[i]) idx = i;
        chk("owner", int'(owner), idx);
        chk("busy_hi", int'(busy), 1);
        chk("uio_out", int'(uio_out), int'(dat_of(idx)));
        chk("uio_oe", int'(uio_oe), int'(oe_of(idx)));
        chk("expired_in_grant", int'(expired), 0);
        if (prev_gnt == 4'b0) begin
          cur_len = 1;
          if (exp_q.size() > 0 && exp_q[0].gap >= 0) chk("gap", gap_cnt, exp_q[0].gap);
        end else begin
          chk("switch_no_gap", int'(gnt), int'(prev_gnt));
          cur_len++;
        end
      end else begin
        chk("uio_oe_idle", int'(uio_oe), 0);
        chk("uio_out_idle", int'(uio_out), 0);
        chk("busy_lo", int'(busy), 0);
        if (prev_gnt != 4'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_tenure", int'(prev_gnt), 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tenure_gnt", int'(prev_gnt), int'(e.gnt));
            chk("tenure_len", cur_len, e.len);
            chk("expired", int'(expired), int'(e.expired));
          end
          gap_cnt = 1;
        end else begin
          chk("expired_idle", int'(expired), 0);
          gap_cnt++;
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      req_data[i*8 +: 8] = dat_of(i);
      req_oe[i*8 +: 8]   = oe_of(i);
    end
    rst = 1'b1; ena = 1'b1; req = 4'b0000;

    // 1: reset state
    cyc(2);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_uio_oe", int'(uio_oe), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_busy", int'(busy), 0);
    mon_en = 1;

    // 2: single requester, released by dropping req after 3 cycles
    rst = 1'b0; req = 4'b0100;
    push(4'b0100, 3, 1'b0, -1);
    cyc(1);
    chk("latency_gnt", int'(gnt), 4'b0100);
    chk("latency_data", int'(uio_out), 8'hC2);
    cyc(2);
    req = 4'b0000;
    cyc(1);
    chk("turn_gnt", int'(gnt), 0);
    chk("turn_uio_oe", int'(uio_oe), 0);
    cyc(3);

    // 3: all requesting, every tenure hits MAX_HOLD, rotation 0,1,2,3,0
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 4'b1111;
    push(4'b0001, 16, 1'b1, -1);
    push(4'b0010, 16, 1'b1, 2);
    push(4'b0100, 16, 1'b1, 2);
    push(4'b1000, 16, 1'b1, 2);
    push(4'b0001, 16, 1'b1, 2);
    cyc(89);
    req = 4'b0000;
    cyc(4);

    // 4: owner drops req on the same cycle hold_cnt reaches MAX_HOLD
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 4'b0110;
    push(4'b0010, 16, 1'b0, -1);
    push(4'b0100, 5, 1'b0, 2);
    cyc(16);
    req = 4'b0100;
    cyc(7);
    req = 4'b0000;
    cyc(4);

    // 5: reset mid-tenure of owner 2, then grant restarts at requester 0
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 4'b0100;
    push(4'b0100, 5, 1'b0, -1);
    cyc(5);
    rst = 1'b1; req = 4'b1111;
    cyc(1);
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_uio_oe", int'(uio_oe), 0);
    chk("midrst_owner", int'(owner), 0);
    rst = 1'b0;
    push(4'b0001, 3, 1'b0, -1);
    cyc(3);
    req = 4'b0000;
    cyc(4);

    // 6: ena low blocks new grants; dropping ena mid-tenure does not end it
    ena = 1'b0; req = 4'b0010;
    cyc(3);
    chk("ena_block", int'(gnt), 0);
    ena = 1'b1;
    push(4'b0010, 2, 1'b0, -1);
    cyc(1);
    chk("ena_grant", int'(gnt), 4'b0010);
    ena = 1'b0;
    cyc(1);
    chk("ena_hold", int'(gnt), 4'b0010);
    req = 4'b0000;
    cyc(3);
    ena = 1'b1;

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc(1);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
